// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: variable-latency req/ack handshake.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rd_data;

    // Fetch stage drives the request, memory answers.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rd_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rd_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake and
// loads the IF/ID register. Redirects on flush / taken branch, parks a word
// that arrives during a stall, and swallows responses of killed fetches.
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        busy,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_insn,
    output logic        if_en
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] stale_addr_q;  // address of the killed request still in flight
    logic [31:0] hold_insn_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_plus4_q;
    logic [31:0] if_insn_q;
    logic        if_en_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect decode and bus outputs, all combinational from state/pc.
    always_comb begin
        // A taken branch loses to a stall; flush wins over both.
        redirect = flush | (br_taken & ~stall);
        target   = flush ? {new_pc[31:2], 2'b00} : {br_addr[31:2], 2'b00};
        pc_plus4 = pc_q + 32'd4;
        imem.imem_req  = (state_q != StHold);
        imem.imem_addr = (state_q == StDiscard) ? stale_addr_q : pc_q;
        busy = ((state_q == StFetch) & ~imem.imem_ack) | (state_q == StDiscard);
    end

    // Fetch FSM, PC and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_VECTOR;
            stale_addr_q  <= 32'h0;
            hold_insn_q   <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_insn_q     <= Nop;
            if_en_q       <= 1'b0;
        end else if (redirect) begin
            pc_q      <= target;
            if_en_q   <= 1'b0;
            if_insn_q <= Nop;
            unique case (state_q)
                StFetch: begin
                    // Outstanding request must drain before the target is issued.
                    if (!imem.imem_ack) begin
                        stale_addr_q <= pc_q;
                        state_q      <= StDiscard;
                    end
                end
                StHold:    state_q <= StFetch;
                StDiscard: state_q <= StDiscard;
                default:   state_q <= StFetch;
            endcase
        end else begin
            // Without a stall an unfilled slot becomes a bubble.
            if (!stall) begin
                if_en_q <= 1'b0;
            end
            unique case (state_q)
                StFetch: begin
                    if (imem.imem_ack) begin
                        if (!stall) begin
                            if_pc_q       <= pc_q;
                            if_pc_plus4_q <= pc_plus4;
                            if_insn_q     <= imem.imem_rd_data;
                            if_en_q       <= 1'b1;
                            pc_q          <= pc_plus4;
                        end else begin
                            hold_insn_q <= imem.imem_rd_data;
                            state_q     <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        if_pc_q       <= pc_q;
                        if_pc_plus4_q <= pc_plus4;
                        if_insn_q     <= hold_insn_q;
                        if_en_q       <= 1'b1;
                        pc_q          <= pc_plus4;
                        state_q       <= StFetch;
                    end
                end
                StDiscard: begin
                    if (imem.imem_ack) begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_insn     = if_insn_q;
    assign if_en       = if_en_q;

endmodule
